// File: rtl/codebook_synthesis_pkg.sv
// codebook_synthesis_pkg
// Shared definitions for the Huffman codebook walker:
//   - FSM state encoding (the numeric values are visible on curr_state)
//   - bit positions of the fields inside a 71-bit node word
//   - child-flag meaning and the helper that decodes it
package codebook_synthesis_pkg;

  typedef enum logic [2:0] {
    ST_LEFT      = 3'd0,
    ST_RIGHT     = 3'd1,
    ST_TRACK     = 3'd2,
    ST_BACKTRACK = 3'd3,
    ST_FINISH    = 3'd4,
    ST_INIT      = 3'd5,
    ST_SEND      = 3'd6
  } state_e;

  // Node word layout: {max_index[6:0], left[8:0], right[8:0], sum[45:0]}
  localparam int NODE_W     = 71;
  localparam int LEFT_MSB   = 63;
  localparam int LEFT_LSB   = 55;
  localparam int RIGHT_MSB  = 54;
  localparam int RIGHT_LSB  = 46;

  // Child field is {flag, value}; flag set means value is a node index
  localparam logic CHILD_NODE = 1'b1;
  localparam logic CHILD_LEAF = 1'b0;

  // Which side of the current node produced the leaf being serialized
  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  function automatic logic child_is_node(input logic [8:0] child);
    return (child[8] == CHILD_NODE);
  endfunction

endpackage

// File: rtl/codebook_synthesis_header_serializer.sv
// header_serializer
// Turns each emitted leaf into a 9-bit header record {1'b1, char} and shifts
// it out MSB first, one bit per cycle, starting the cycle after char_found.
// write_finish pulses for one cycle right after the last bit.
// Ports:
//   clk, rst            clock, async active-low reset
//   char_found          one-cycle leaf pulse from the walker
//   char_index[7:0]     leaf character
//   header[8:0]         last latched record
//   bit1, enable        serial bit and its qualifier
//   write_finish        record complete pulse
module header_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_found,
  input  logic [7:0] char_index,
  output logic [8:0] header,
  output logic       bit1,
  output logic       enable,
  output logic       write_finish
);

  logic [8:0] r_header;
  logic [7:0] r_shift;        // bits still to send, next one at [7]
  logic [3:0] r_cnt;          // number of bits still in r_shift
  logic       r_bit1;
  logic       r_enable;
  logic       r_write_finish;

  // Load the record on char_found, then shift it out and flag completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_header       <= 9'd0;
      r_shift        <= 8'd0;
      r_cnt          <= 4'd0;
      r_bit1         <= 1'b0;
      r_enable       <= 1'b0;
      r_write_finish <= 1'b0;
    end else if (char_found) begin
      // The leading 1 goes out immediately; the character follows
      r_header       <= {1'b1, char_index};
      r_bit1         <= 1'b1;
      r_enable       <= 1'b1;
      r_shift        <= char_index;
      r_cnt          <= 4'd8;
      r_write_finish <= 1'b0;
    end else if (r_cnt != 4'd0) begin
      r_bit1         <= r_shift[7];
      r_shift        <= {r_shift[6:0], 1'b0};
      r_cnt          <= r_cnt - 4'd1;
      r_enable       <= 1'b1;
      r_write_finish <= 1'b0;
    end else if (r_enable) begin
      // Last bit was on the line during the previous cycle
      r_bit1         <= 1'b0;
      r_enable       <= 1'b0;
      r_write_finish <= 1'b1;
    end else begin
      r_bit1         <= 1'b0;
      r_enable       <= 1'b0;
      r_write_finish <= 1'b0;
    end
  end

  assign header       = r_header;
  assign bit1         = r_bit1;
  assign enable       = r_enable;
  assign write_finish = r_write_finish;

endmodule

// File: rtl/codebook_synthesis.sv
// codebook_synthesis
// Depth-first walk of a Huffman tree in external node memory. Every leaf is
// reported with its code on char_found/char_index/char_path and then
// serialized as a header record by header_serializer.
// Ports:
//   clk, rst               clock, async active-low reset
//   max_index[6:0]         root node index
//   h_element[70:0]        node word at curr_index (one cycle latency)
//   curr_index[6:0]        node address being fetched
//   curr_state[2:0]        FSM state
//   curr_path[127:0]       path to current node, LSB = latest decision
//   track_length[6:0]      depth of current node
//   pos[6:0]               TRACK step counter
//   wait_cycle             memory-latency cycle
//   least1/least2[8:0]     left/right child of current node
//   char_found, char_index[7:0], char_path[127:0]   leaf report
//   finished[3:0]          4'b0001 in FINISH
//   write_finish, bit1, enable, header[8:0]         header record output
module codebook_synthesis
  import codebook_synthesis_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   max_index,
  input  logic [70:0]  h_element,
  output logic [6:0]   curr_index,
  output logic [2:0]   curr_state,
  output logic [127:0] curr_path,
  output logic [6:0]   track_length,
  output logic [6:0]   pos,
  output logic         wait_cycle,
  output logic [8:0]   least1,
  output logic [8:0]   least2,
  output logic         char_found,
  output logic [7:0]   char_index,
  output logic [127:0] char_path,
  output logic [3:0]   finished,
  output logic         write_finish,
  output logic         bit1,
  output logic         enable,
  output logic [8:0]   header
);

  state_e         r_state, w_state_nxt;
  logic [127:0]   r_path, w_path_nxt;
  logic [6:0]     r_len, w_len_nxt;
  logic [6:0]     r_pos, w_pos_nxt;
  logic [6:0]     r_curr_index, w_fetch_addr;
  logic           r_addr_ph;      // address cycle of a fetch
  logic           r_wait;         // latency cycle of a fetch
  logic [8:0]     r_least1, r_least2;
  logic           r_char_found, w_char_found;
  logic [7:0]     r_char_index, w_char_index_nxt;
  logic [127:0]   r_char_path, w_char_path_nxt;
  logic [3:0]     r_finished;
  logic           r_side, w_side_nxt;
  logic           w_fetch;
  logic           w_busy;
  logic [6:0]     w_bit_idx;
  logic           w_write_finish;
  logic           w_unused_node_bits;

  // Max-index and subtree-sum fields are not needed for code generation
  assign w_unused_node_bits = ^{h_element[70:64], h_element[45:0]};

  // The FSM only acts once the node fetch has landed in least1/least2
  assign w_busy = r_addr_ph | r_wait;

  // Next-state and datapath decisions for the tree walk
  always_comb begin
    w_state_nxt      = r_state;
    w_path_nxt       = r_path;
    w_len_nxt        = r_len;
    w_pos_nxt        = r_pos;
    w_fetch          = 1'b0;
    w_fetch_addr     = r_curr_index;
    w_char_found     = 1'b0;
    w_char_index_nxt = r_char_index;
    w_char_path_nxt  = r_char_path;
    w_side_nxt       = r_side;
    // TRACK replays the surviving path oldest decision first
    w_bit_idx        = r_len - r_pos - 7'd1;
    if (!w_busy) begin
      case (r_state)
        ST_INIT: begin
          w_path_nxt   = 128'd0;
          w_len_nxt    = 7'd0;
          w_pos_nxt    = 7'd0;
          w_fetch      = 1'b1;
          w_fetch_addr = max_index;
          w_state_nxt  = ST_LEFT;
        end
        ST_LEFT: begin
          if (child_is_node(r_least1)) begin
            w_path_nxt   = {r_path[126:0], 1'b0};
            w_len_nxt    = r_len + 7'd1;
            w_fetch      = 1'b1;
            w_fetch_addr = r_least1[6:0];
          end else begin
            w_char_index_nxt = r_least1[7:0];
            w_char_path_nxt  = {r_path[126:0], 1'b0};
            w_char_found     = 1'b1;
            w_side_nxt       = SIDE_LEFT;
            w_state_nxt      = ST_SEND;
          end
        end
        ST_RIGHT: begin
          if (child_is_node(r_least2)) begin
            w_path_nxt   = {r_path[126:0], 1'b1};
            w_len_nxt    = r_len + 7'd1;
            w_fetch      = 1'b1;
            w_fetch_addr = r_least2[6:0];
            w_state_nxt  = ST_LEFT;
          end else begin
            w_char_index_nxt = r_least2[7:0];
            w_char_path_nxt  = {r_path[126:0], 1'b1};
            w_char_found     = 1'b1;
            w_side_nxt       = SIDE_RIGHT;
            w_state_nxt      = ST_SEND;
          end
        end
        ST_SEND: begin
          // After a left leaf the same node's right child is still loaded
          if (w_write_finish) begin
            w_state_nxt = (r_side == SIDE_RIGHT) ? ST_BACKTRACK : ST_RIGHT;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
        ST_BACKTRACK: begin
          if (r_len == 7'd0) begin
            w_state_nxt = ST_FINISH;
          end else if (r_path[0]) begin
            // Right branch already explored: keep climbing
            w_path_nxt = {1'b0, r_path[127:1]};
            w_len_nxt  = r_len - 7'd1;
          end else begin
            // Left branch done: re-descend from root to reach its parent
            w_path_nxt   = {1'b0, r_path[127:1]};
            w_len_nxt    = r_len - 7'd1;
            w_pos_nxt    = 7'd0;
            w_fetch      = 1'b1;
            w_fetch_addr = max_index;
            w_state_nxt  = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (r_pos < r_len) begin
            w_fetch      = 1'b1;
            w_fetch_addr = r_path[w_bit_idx] ? r_least2[6:0] : r_least1[6:0];
            w_pos_nxt    = r_pos + 7'd1;
          end else begin
            w_state_nxt = ST_RIGHT;
          end
        end
        ST_FINISH: begin
          w_state_nxt = ST_FINISH;
        end
        default: begin
          w_state_nxt = ST_INIT;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Path, leaf report and node-fetch sequencing registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_path       <= 128'd0;
      r_len        <= 7'd0;
      r_pos        <= 7'd0;
      r_curr_index <= 7'd0;
      r_addr_ph    <= 1'b0;
      r_wait       <= 1'b0;
      r_least1     <= 9'd0;
      r_least2     <= 9'd0;
      r_char_found <= 1'b0;
      r_char_index <= 8'd0;
      r_char_path  <= 128'd0;
      r_finished   <= 4'd0;
      r_side       <= 1'b0;
    end else begin
      r_path       <= w_path_nxt;
      r_len        <= w_len_nxt;
      r_pos        <= w_pos_nxt;
      r_char_found <= w_char_found;
      r_char_index <= w_char_index_nxt;
      r_char_path  <= w_char_path_nxt;
      r_side       <= w_side_nxt;
      r_finished   <= (w_state_nxt == ST_FINISH) ? 4'b0001 : 4'b0000;
      if (w_fetch) begin
        r_curr_index <= w_fetch_addr;
        r_addr_ph    <= 1'b1;
        r_wait       <= 1'b0;
      end else if (r_addr_ph) begin
        r_addr_ph    <= 1'b0;
        r_wait       <= 1'b1;
      end else if (r_wait) begin
        r_wait       <= 1'b0;
        r_least1     <= h_element[LEFT_MSB:LEFT_LSB];
        r_least2     <= h_element[RIGHT_MSB:RIGHT_LSB];
      end else begin
        r_addr_ph    <= 1'b0;
        r_wait       <= 1'b0;
      end
    end
  end

  header_serializer u_header_serializer (
    .clk          (clk),
    .rst          (rst),
    .char_found   (r_char_found),
    .char_index   (r_char_index),
    .header       (header),
    .bit1         (bit1),
    .enable       (enable),
    .write_finish (w_write_finish)
  );

  assign curr_index   = r_curr_index;
  assign curr_state   = r_state;
  assign curr_path    = r_path;
  assign track_length = r_len;
  assign pos          = r_pos;
  assign wait_cycle   = r_wait;
  assign least1       = r_least1;
  assign least2       = r_least2;
  assign char_found   = r_char_found;
  assign char_index   = r_char_index;
  assign char_path    = r_char_path;
  assign finished     = r_finished;
  assign write_finish = w_write_finish;

endmodule

// File: tb/tb_codebook_synthesis.sv
module tb_codebook_synthesis;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [6:0]   max_index = 7'd8;
  logic [70:0]  h_element = 71'd0;
  logic [6:0]   curr_index;
  logic [2:0]   curr_state;
  logic [127:0] curr_path;
  logic [6:0]   track_length;
  logic [6:0]   pos;
  logic         wait_cycle;
  logic [8:0]   least1, least2;
  logic         char_found;
  logic [7:0]   char_index;
  logic [127:0] char_path;
  logic [3:0]   finished;
  logic         write_finish;
  logic         bit1;
  logic         enable;
  logic [8:0]   header;

  codebook_synthesis dut (
    .clk(clk), .rst(rst), .max_index(max_index), .h_element(h_element),
    .curr_index(curr_index), .curr_state(curr_state), .curr_path(curr_path),
    .track_length(track_length), .pos(pos), .wait_cycle(wait_cycle),
    .least1(least1), .least2(least2), .char_found(char_found),
    .char_index(char_index), .char_path(char_path), .finished(finished),
    .write_finish(write_finish), .bit1(bit1), .enable(enable), .header(header)
  );

  always #5 clk = ~clk;

  // Node memory with one cycle of read latency
  logic [70:0] mem [0:127];
  always @(posedge clk) h_element <= mem[curr_index];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] nd(input logic [8:0] l, input logic [8:0] r);
    return {7'd8, l, r, 46'd0};
  endfunction

  // Expected leaf table (hand-computed from the test tree)
  logic [7:0]   leaf_ch  [10] = '{8'h43, 8'h42, 8'h41, 8'h46, 8'h44, 8'h45, 8'h4A, 8'h47, 8'h48, 8'h49};
  logic [127:0] leaf_pth [10] = '{128'd0, 128'd1, 128'd1, 128'd2, 128'd6, 128'd7, 128'd2, 128'd6, 128'd14, 128'd15};
  int           leaf_len [10] = '{4, 4, 3, 3, 4, 4, 2, 3, 4, 4};
  int           exp_bt   [4]  = '{1, 1, 3, 4};
  int           exp_tr   [3]  = '{2, 1, 0};

  typedef struct {
    logic [7:0]   ch;
    logic [127:0] path;
    int           len;
  } leaf_t;

  leaf_t      exp_q[$];
  logic [8:0] hdr_q[$];
  int         bt_obs[$];
  int         tr_obs[$];

  task automatic push_leaves(input int n);
    leaf_t e;
    for (int i = 0; i < n; i++) begin
      e.ch = leaf_ch[i]; e.path = leaf_pth[i]; e.len = leaf_len[i];
      exp_q.push_back(e);
      hdr_q.push_back({1'b1, leaf_ch[i]});
    end
  endtask

  // Monitor: leaf reports, header stream, backtrack/track episodes
  logic [8:0] bits;
  int         nb, lat, bt_cnt;
  logic [2:0] prev_state = 3'd5;
  always @(negedge clk) begin
    if (rst) begin
      if (char_found) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_leaf: got char %0h expected none", char_index);
        end else begin
          leaf_t e;
          e = exp_q.pop_front();
          chk("char_index", 128'(char_index), 128'(e.ch));
          chk("char_path", char_path, e.path);
          chk("code_len", 128'(track_length + 7'd1), 128'(e.len));
        end
        bits = 9'd0; nb = 0; lat = 0;
      end else begin
        lat++;
      end
      if (enable) begin
        bits = {bits[7:0], bit1};
        nb++;
      end
      if (write_finish) begin
        if (hdr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write_finish: got header %0h expected none", header);
        end else begin
          logic [8:0] h;
          h = hdr_q.pop_front();
          chk("header", 128'(header), 128'(h));
          chk("bit_stream", 128'(bits), 128'(h));
          chk("bit_count", 128'(nb), 128'd9);
          chk("wf_latency", 128'(lat), 128'd10);
        end
      end
      if (curr_state == 3'd3) bt_cnt++;
      else if (prev_state == 3'd3) begin
        bt_obs.push_back(bt_cnt);
        bt_cnt = 0;
      end
      if (curr_state == 3'd2 && prev_state != 3'd2) tr_obs.push_back(int'(track_length));
      prev_state = curr_state;
    end else begin
      bt_cnt = 0;
      prev_state = 3'd5;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 128'(curr_state), 128'd5);
    chk({tag, "_paths"}, curr_path | char_path, 128'd0);
    chk({tag, "_misc"}, 128'({curr_index, track_length, pos, wait_cycle, least1, least2,
                              char_found, char_index, finished, write_finish, bit1, enable, header}),
        128'd0);
  endtask

  task automatic run_to_finish(input string tag);
    int cyc = 0;
    while (finished !== 4'b0001 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_reach_finish"}, 128'(finished), 128'd1);
    chk({tag, "_finish_state"}, 128'(curr_state), 128'd4);
    repeat (20) @(negedge clk);
    chk({tag, "_leaves_left"}, 128'(exp_q.size()), 128'd0);
    chk({tag, "_headers_left"}, 128'(hdr_q.size()), 128'd0);
    chk({tag, "_still_finish"}, 128'(curr_state), 128'd4);
    chk({tag, "_bt_episodes"}, 128'(bt_obs.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_bt_len%0d", tag, i), 128'(i < bt_obs.size() ? bt_obs[i] : -1), 128'(exp_bt[i]));
    chk({tag, "_tr_episodes"}, 128'(tr_obs.size()), 128'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_tr_len%0d", tag, i), 128'(i < tr_obs.size() ? tr_obs[i] : -1), 128'(exp_tr[i]));
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 128; i++) mem[i] = 71'd0;
    mem[8] = nd({1'b1, 8'd6},  {1'b1, 8'd7});
    mem[6] = nd({1'b1, 8'd3},  {1'b1, 8'd4});
    mem[3] = nd({1'b1, 8'd0},  {1'b0, 8'h41});
    mem[0] = nd({1'b0, 8'h43}, {1'b0, 8'h42});
    mem[4] = nd({1'b0, 8'h46}, {1'b1, 8'd1});
    mem[1] = nd({1'b0, 8'h44}, {1'b0, 8'h45});
    mem[7] = nd({1'b0, 8'h4A}, {1'b1, 8'd5});
    mem[5] = nd({1'b0, 8'h47}, {1'b1, 8'd2});
    mem[2] = nd({1'b0, 8'h48}, {1'b0, 8'h49});

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");

    // First run: full traversal
    push_leaves(10);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("init_to_left", 128'(curr_state), 128'd0);
    chk("root_fetch", 128'(curr_index), 128'd8);
    chk("addr_cycle_no_wait", 128'(wait_cycle), 128'd0);
    @(posedge clk); #1;
    chk("wait_cycle_pulse", 128'(wait_cycle), 128'd1);
    @(posedge clk); #1;
    chk("wait_cycle_drop", 128'(wait_cycle), 128'd0);
    chk("root_least1", 128'(least1), 128'h106);
    run_to_finish("run1");

    // Second run: abort with reset during the first TRACK
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    bt_obs.delete(); tr_obs.delete();
    push_leaves(2);
    cyc = 0;
    while (curr_state !== 3'd2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_track", 128'(curr_state), 128'd2);
    chk("run2_leaves_before_track", 128'(exp_q.size()), 128'd0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrun_reset");

    // Third run: traversal after mid-run reset must repeat exactly
    @(negedge clk);
    bt_obs.delete(); tr_obs.delete();
    exp_q.delete(); hdr_q.delete();
    push_leaves(10);
    rst = 1'b1;
    run_to_finish("run3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
